// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_t : two-state arbiter FSM encoding (IDLE / GRANT)
//   - rr_pick()   : round-robin search helper used by rr_pick_next
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Upper bound on requester count supported by rr_pick(); the request
  // vector is zero-extended to this width before the search.
  localparam int MAX_NREQ = 32;
  localparam int MAX_IDXW = $clog2(MAX_NREQ);

  // Returns the first index with valid set, searching last+1, last+2, ...
  // wrapping modulo nreq, with 'last' itself checked last. Returns 'last'
  // when nothing is valid (callers gate on any-valid separately).
  // The loop runs from the farthest offset to the nearest so the nearest
  // hit overwrites the result; this avoids a break and keeps it a pure
  // priority chain after unrolling. Wrap is an explicit subtract, so
  // non-power-of-2 nreq works.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid,
                                 input int                  last,
                                 input int                  nreq);
    int idx;
    idx     = 0;
    rr_pick = last;
    for (int off = MAX_NREQ; off >= 1; off--) begin
      if (off <= nreq) begin
        idx = last + off;
        if (idx >= nreq) idx = idx - nreq;
        if (valid[idx[MAX_IDXW-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// -----------------------------------------------------------------------------
// rr_pick_next
//   Combinational round-robin priority selector, generic in NREQ.
//   Ports:
//     valid [NREQ-1:0]  request vector
//     last  [IDXW-1:0]  index granted most recently (lowest priority now)
//     next  [IDXW-1:0]  first valid index after 'last', wrapping modulo NREQ
//     any               at least one request is valid (next is meaningful)
// -----------------------------------------------------------------------------
module rr_pick_next
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] next,
  output logic            any
);

  logic [MAX_NREQ-1:0] valid_ext;

  assign valid_ext = MAX_NREQ'(valid);
  assign any       = |valid;
  assign next      = IDXW'(rr_pick(valid_ext, int'(last), NREQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between NREQ producers.
//   One owner at a time is granted for a burst of up to BURST beats; the
//   grant is released early when the owner drops valid. One IDLE bubble
//   separates consecutive grants.
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     req_valid/ready    per-requester handshake (beat = valid & ready)
//     req_data           flattened data, requester i at [i*DWIDTH +: DWIDTH]
//     fifo_full          FIFO full flag; stalls the burst without releasing
//     fifo_wr_en/din     FIFO write pins (din is zero when not writing)
//     grant              one-hot owner, zero when idle
//     busy               high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_din,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(BURST + 1);

  localparam logic [CNTW-1:0] LAST_BEAT   = CNTW'(BURST - 1);
  // Starting with the last index as previous owner gives requester 0 first
  // priority out of reset.
  localparam logic [IDXW-1:0] RESET_OWNER = IDXW'(NREQ - 1);

  arb_state_t      state_q,      state_d;
  logic [IDXW-1:0] owner_q,      owner_d;
  logic [IDXW-1:0] last_owner_q, last_owner_d;
  logic [CNTW-1:0] beat_cnt_q,   beat_cnt_d;

  logic [IDXW-1:0] pick_idx;
  logic            any_valid;
  logic            owner_valid;
  logic            accept;

  // Unpacked view of the flattened data bus so the owner mux is a plain
  // array index rather than a computed part-select.
  logic [DWIDTH-1:0] slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DWIDTH +: DWIDTH];
  end

  rr_pick_next #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .valid (req_valid),
    .last  (last_owner_q),
    .next  (pick_idx),
    .any   (any_valid)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= RESET_OWNER;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  // Outputs are decoded from registered state, so an asynchronous reset
  // drops grant/ready/wr_en in the same instant, with no edge required.
  assign owner_valid = req_valid[owner_q];
  assign accept      = (state_q == GRANT) && owner_valid && !fifo_full;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;

    req_ready    = '0;
    grant        = '0;
    fifo_wr_en   = 1'b0;
    fifo_din     = '0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end

      GRANT: begin
        busy             = 1'b1;
        grant[owner_q]   = 1'b1;
        // Ready depends only on FIFO space; the transfer itself also needs
        // the owner's valid, which is what wr_en reflects.
        req_ready[owner_q] = !fifo_full;
        fifo_wr_en       = accept;
        if (accept) fifo_din = slice[owner_q];

        if (!owner_valid) begin
          // Owner withdrew (even while full): forfeit the rest of the burst.
          state_d      = IDLE;
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
        end else if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        // Full with valid held: counter and grant hold.
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter: a default build (NREQ=4, BURST=4)
//   and a small build (NREQ=3, BURST=1) sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;

  // Default build
  logic [3:0]      valid_a;
  logic [4*DW-1:0] data_a;
  logic [3:0]      ready_a;
  logic            full_a;
  logic            wr_en_a;
  logic [DW-1:0]   din_a;
  logic [3:0]      grant_a;
  logic            busy_a;

  // NREQ=3, BURST=1 build
  logic [2:0]      valid_b;
  logic [3*DW-1:0] data_b;
  logic [2:0]      ready_b;
  logic            full_b;
  logic            wr_en_b;
  logic [DW-1:0]   din_b;
  logic [2:0]      grant_b;
  logic            busy_b;

  logic [DW-1:0] da [4];
  logic [DW-1:0] db [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(DW), .BURST(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (valid_a),
    .req_data   (data_a),
    .req_ready  (ready_a),
    .fifo_full  (full_a),
    .fifo_wr_en (wr_en_a),
    .fifo_din   (din_a),
    .grant      (grant_a),
    .busy       (busy_a)
  );

  fifo_wr_arbiter #(.NREQ(3), .DWIDTH(DW), .BURST(1)) dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (valid_b),
    .req_data   (data_b),
    .req_ready  (ready_b),
    .fifo_full  (full_b),
    .fifo_wr_en (wr_en_b),
    .fifo_din   (din_b),
    .grant      (grant_b),
    .busy       (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between edges.
  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh4;
    logic [2:0] oh3;

    da[0] = 32'h1111_0000; da[1] = 32'h2222_0001;
    da[2] = 32'h3333_0002; da[3] = 32'h4444_0003;
    db[0] = 32'hB0B0_0000; db[1] = 32'hB1B1_0001; db[2] = 32'hB2B2_0002;

    rstn    = 1'b0;
    valid_a = '0;
    full_a  = 1'b0;
    valid_b = '0;
    full_b  = 1'b0;
    for (int i = 0; i < 4; i++) data_a[i*DW +: DW] = da[i];
    for (int i = 0; i < 3; i++) data_b[i*DW +: DW] = db[i];

    // ---- 1: reset values, single requester burst, regrant after bubble ----
    #1;
    check("rst_grant", grant_a, 4'b0000);
    check("rst_ready", ready_a, 4'b0000);
    check("rst_wr_en", wr_en_a, 1'b0);
    check("rst_din",   din_a,   32'h0);
    check("rst_busy",  busy_a,  1'b0);
    tick();
    tick();
    rstn    = 1'b1;
    valid_a = 4'b0001;
    #1;
    check("t1_idle_grant", grant_a, 4'b0000);
    check("t1_idle_wr_en", wr_en_a, 1'b0);
    tick();
    check("t1_busy",  busy_a,  1'b1);
    check("t1_ready", ready_a, 4'b0001);
    for (int b = 0; b < 4; b++) begin
      check("t1_grant", grant_a, 4'b0001);
      check("t1_wr_en", wr_en_a, 1'b1);
      check("t1_din",   din_a,   da[0]);
      tick();
    end
    check("t1_bubble_grant", grant_a, 4'b0000);
    check("t1_bubble_wr_en", wr_en_a, 1'b0);
    check("t1_bubble_busy",  busy_a,  1'b0);
    tick();
    check("t1_regrant", grant_a, 4'b0001);
    valid_a = 4'b0000;
    #1;
    check("t1_drop_wr_en", wr_en_a, 1'b0);
    tick();
    check("t1_drop_grant", grant_a, 4'b0000);

    // ---- 2: all valid, strict rotation 0,1,2,3,0 with 4 beats each --------
    pulse_reset();
    valid_a = 4'b1111;
    #1;
    tick();
    for (int g = 0; g < 5; g++) begin
      oh4 = 4'b0001 << (g % 4);
      for (int b = 0; b < 4; b++) begin
        check("t2_grant", grant_a, oh4);
        check("t2_wr_en", wr_en_a, 1'b1);
        check("t2_din",   din_a,   da[g % 4]);
        tick();
      end
      check("t2_bubble_grant", grant_a, 4'b0000);
      check("t2_bubble_wr_en", wr_en_a, 1'b0);
      tick();
    end
    valid_a = 4'b0000;
    tick();
    tick();

    // ---- 3: owner 1 stalled by full after 2 beats -------------------------
    pulse_reset();
    valid_a = 4'b0010;
    #1;
    tick();
    check("t3_grant", grant_a, 4'b0010);
    check("t3_wr_en0", wr_en_a, 1'b1);
    tick();
    check("t3_wr_en1", wr_en_a, 1'b1);
    tick();
    full_a = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_full_wr_en", wr_en_a, 1'b0);
      check("t3_full_din",   din_a,   32'h0);
      check("t3_full_ready", ready_a, 4'b0000);
      check("t3_full_grant", grant_a, 4'b0010);
      check("t3_full_cnt",   dut.beat_cnt_q, 3'd2);
      tick();
    end
    full_a = 1'b0;
    #1;
    check("t3_resume_wr_en", wr_en_a, 1'b1);
    check("t3_resume_din",   din_a,   da[1]);
    tick();
    check("t3_last_wr_en", wr_en_a, 1'b1);
    tick();
    check("t3_release_grant", grant_a, 4'b0000);
    check("t3_release_wr_en", wr_en_a, 1'b0);
    valid_a = 4'b0000;

    // ---- 4: owner 2 drops valid after 1 beat, requester 3 waiting ---------
    valid_a = 4'b1100;
    #1;
    tick();
    check("t4_grant", grant_a, 4'b0100);
    check("t4_din",   din_a,   da[2]);
    tick();
    valid_a = 4'b1000;
    #1;
    check("t4_drop_wr_en", wr_en_a, 1'b0);
    check("t4_drop_grant", grant_a, 4'b0100);
    tick();
    check("t4_idle_grant", grant_a, 4'b0000);
    check("t4_idle_busy",  busy_a,  1'b0);
    check("t4_last_owner", dut.last_owner_q, 2'd2);
    tick();
    check("t4_grant3", grant_a, 4'b1000);
    check("t4_din3",   din_a,   da[3]);

    // ---- 5: asynchronous reset mid-burst ----------------------------------
    tick();
    check("t5_pre_wr_en", wr_en_a, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    check("t5_rst_grant", grant_a, 4'b0000);
    check("t5_rst_wr_en", wr_en_a, 1'b0);
    check("t5_rst_ready", ready_a, 4'b0000);
    check("t5_rst_din",   din_a,   32'h0);
    tick();
    check("t5_rst_hold_wr_en", wr_en_a, 1'b0);
    rstn    = 1'b1;
    valid_a = 4'b1001;
    #1;
    tick();
    check("t5_prio_grant", grant_a, 4'b0001);
    check("t5_prio_din",   din_a,   da[0]);
    valid_a = 4'b0000;
    tick();
    tick();

    // ---- 6: NREQ=3, BURST=1, all valid -> 0,1,2 with bubbles ---------------
    pulse_reset();
    valid_b = 3'b111;
    #1;
    check("t6_idle_grant", grant_b, 3'b000);
    tick();
    for (int g = 0; g < 6; g++) begin
      oh3 = 3'b001 << (g % 3);
      check("t6_grant", grant_b, oh3);
      check("t6_wr_en", wr_en_b, 1'b1);
      check("t6_din",   din_b,   db[g % 3]);
      tick();
      check("t6_bubble_wr_en", wr_en_b, 1'b0);
      check("t6_bubble_grant", grant_b, 3'b000);
      tick();
    end
    valid_b = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
